// File: rtl/ysyx_22040931_wb_stage_pkg.sv
// Shared encodings for the ysyx_22040931 writeback stage:
// result select and load format codes.
package ysyx_22040931_wb_stage_pkg;

   typedef enum logic [1:0] {
      WB_SEL_ALU  = 2'd0,
      WB_SEL_LOAD = 2'd1,
      WB_SEL_PC4  = 2'd2,
      WB_SEL_CSR  = 2'd3
   } wb_sel_e;

   typedef enum logic [2:0] {
      LD_FMT_LB   = 3'd0,
      LD_FMT_LH   = 3'd1,
      LD_FMT_LW   = 3'd2,
      LD_FMT_LD   = 3'd3,
      LD_FMT_LBU  = 3'd4,
      LD_FMT_LHU  = 3'd5,
      LD_FMT_LWU  = 3'd6,
      LD_FMT_RSVD = 3'd7
   } ld_fmt_e;

   localparam int PC_INC = 4;

endpackage

// File: rtl/ysyx_22040931_wb_stage_load_ext.sv
// Load lane extraction and sign/zero extension.
// Misaligned offsets are truncated down to the access size.
module ysyx_22040931_load_ext
   import ysyx_22040931_wb_stage_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [XLEN-1:0] rdata,
   input  logic [2:0]      off,
   input  logic [2:0]      fmt,
   output logic [XLEN-1:0] data
);

   logic [2:0]  eoff;
   logic [5:0]  b_sh;
   logic [5:0]  h_sh;
   logic [5:0]  w_sh;
   logic [7:0]  b;
   logic [15:0] h;
   logic [31:0] w;

   always_comb begin
      // A 32-bit datapath has only four byte lanes.
      eoff = (XLEN == 64) ? off : {1'b0, off[1:0]};
      b_sh = {eoff, 3'b000};
      h_sh = {eoff[2:1], 4'b0000};
      w_sh = {eoff[2], 5'b00000};
      b    = 8'(rdata >> b_sh);
      h    = 16'(rdata >> h_sh);
      w    = 32'(rdata >> w_sh);
      data = rdata;
      unique case (ld_fmt_e'(fmt))
         LD_FMT_LB:   data = XLEN'($signed(b));
         LD_FMT_LH:   data = XLEN'($signed(h));
         LD_FMT_LW:   data = XLEN'($signed(w));
         LD_FMT_LBU:  data = XLEN'(b);
         LD_FMT_LHU:  data = XLEN'(h);
         LD_FMT_LWU:  data = XLEN'(w);
         LD_FMT_LD,
         LD_FMT_RSVD: data = (XLEN == 64) ? rdata : XLEN'(w);
      endcase
   end

endmodule

// File: rtl/ysyx_22040931_wb_stage.sv
// Writeback stage: one-entry valid/ready register, result select,
// retire port with instret counter and a forwarding port.
module ysyx_22040931_wb_stage
   import ysyx_22040931_wb_stage_pkg::*;
#(
   parameter int XLEN = 64,
   parameter int PC_W = 64,
   parameter int RA_W = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [PC_W-1:0] in_pc,
   input  logic [RA_W-1:0] in_rd,
   input  logic            in_rd_we,
   input  logic [1:0]      in_sel,
   input  logic [XLEN-1:0] in_alu,
   input  logic [XLEN-1:0] in_csr,
   input  logic [XLEN-1:0] in_mem_rdata,
   input  logic [2:0]      in_mem_off,
   input  logic [2:0]      in_mem_fmt,
   input  logic            commit_ready,
   output logic            rf_we,
   output logic [RA_W-1:0] rf_waddr,
   output logic [XLEN-1:0] rf_wdata,
   output logic            commit_valid,
   output logic [PC_W-1:0] commit_pc,
   output logic            fwd_valid,
   output logic [RA_W-1:0] fwd_addr,
   output logic [XLEN-1:0] fwd_data,
   output logic [63:0]     instret
);

   logic            valid_q,   valid_d;
   logic [PC_W-1:0] pc_q,      pc_d;
   logic [RA_W-1:0] rd_q,      rd_d;
   logic            rd_we_q,   rd_we_d;
   logic [1:0]      sel_q,     sel_d;
   logic [XLEN-1:0] alu_q,     alu_d;
   logic [XLEN-1:0] csr_q,     csr_d;
   logic [XLEN-1:0] rdata_q,   rdata_d;
   logic [2:0]      off_q,     off_d;
   logic [2:0]      fmt_q,     fmt_d;
   logic [63:0]     instret_q, instret_d;

   logic            accept;
   logic            retire;
   logic            wr_rd;
   logic [PC_W-1:0] pc4;
   logic [XLEN-1:0] ld_data;
   logic [XLEN-1:0] result;

   ysyx_22040931_load_ext #(
      .XLEN (XLEN)
   ) u_load_ext (
      .rdata (rdata_q),
      .off   (off_q),
      .fmt   (fmt_q),
      .data  (ld_data)
   );

   always_comb begin
      in_ready  = !valid_q || commit_ready;
      accept    = in_valid && in_ready;
      retire    = valid_q && commit_ready;
      valid_d   = valid_q;
      pc_d      = pc_q;
      rd_d      = rd_q;
      rd_we_d   = rd_we_q;
      sel_d     = sel_q;
      alu_d     = alu_q;
      csr_d     = csr_q;
      rdata_d   = rdata_q;
      off_d     = off_q;
      fmt_d     = fmt_q;
      instret_d = retire ? instret_q + 64'd1 : instret_q;
      // A retire in the same cycle as an accept keeps the entry valid.
      if (accept) begin
         valid_d = 1'b1;
         pc_d    = in_pc;
         rd_d    = in_rd;
         rd_we_d = in_rd_we;
         sel_d   = in_sel;
         alu_d   = in_alu;
         csr_d   = in_csr;
         rdata_d = in_mem_rdata;
         off_d   = in_mem_off;
         fmt_d   = in_mem_fmt;
      end else if (retire) begin
         valid_d = 1'b0;
      end
   end

   always_comb begin
      pc4    = pc_q + PC_W'(PC_INC);
      result = alu_q;
      unique case (wb_sel_e'(sel_q))
         WB_SEL_ALU:  result = alu_q;
         WB_SEL_LOAD: result = ld_data;
         WB_SEL_PC4:  result = XLEN'(pc4);
         WB_SEL_CSR:  result = csr_q;
      endcase
      wr_rd        = rd_we_q && (rd_q != '0);
      rf_we        = retire && wr_rd;
      rf_waddr     = rd_q;
      rf_wdata     = result;
      commit_valid = retire;
      commit_pc    = pc_q;
      fwd_valid    = valid_q && wr_rd;
      fwd_addr     = rd_q;
      fwd_data     = result;
      instret      = instret_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q   <= 1'b0;
         pc_q      <= '0;
         rd_q      <= '0;
         rd_we_q   <= 1'b0;
         sel_q     <= '0;
         alu_q     <= '0;
         csr_q     <= '0;
         rdata_q   <= '0;
         off_q     <= '0;
         fmt_q     <= '0;
         instret_q <= '0;
      end else begin
         valid_q   <= valid_d;
         pc_q      <= pc_d;
         rd_q      <= rd_d;
         rd_we_q   <= rd_we_d;
         sel_q     <= sel_d;
         alu_q     <= alu_d;
         csr_q     <= csr_d;
         rdata_q   <= rdata_d;
         off_q     <= off_d;
         fmt_q     <= fmt_d;
         instret_q <= instret_d;
      end
   end

endmodule

// File: tb/tb_ysyx_22040931_wb_stage.sv
// Bench for ysyx_22040931_wb_stage: vector table, directed corner
// sequences and random traffic against a one-entry reference model.
module tb_ysyx_22040931_wb_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_pc;
   logic [4:0]  in_rd;
   logic        in_rd_we;
   logic [1:0]  in_sel;
   logic [63:0] in_alu;
   logic [63:0] in_csr;
   logic [63:0] in_mem_rdata;
   logic [2:0]  in_mem_off;
   logic [2:0]  in_mem_fmt;
   logic        commit_ready;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [63:0] rf_wdata;
   logic        commit_valid;
   logic [63:0] commit_pc;
   logic        fwd_valid;
   logic [4:0]  fwd_addr;
   logic [63:0] fwd_data;
   logic [63:0] instret;

   int n_checks = 0;
   int n_err    = 0;

   bit          m_valid;
   logic [63:0] m_pc;
   logic [4:0]  m_rd;
   bit          m_we;
   logic [63:0] m_res;
   logic [63:0] m_instret;

   always #5 clk = ~clk;

   ysyx_22040931_wb_stage #(
      .XLEN (64),
      .PC_W (64),
      .RA_W (5)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_pc        (in_pc),
      .in_rd        (in_rd),
      .in_rd_we     (in_rd_we),
      .in_sel       (in_sel),
      .in_alu       (in_alu),
      .in_csr       (in_csr),
      .in_mem_rdata (in_mem_rdata),
      .in_mem_off   (in_mem_off),
      .in_mem_fmt   (in_mem_fmt),
      .commit_ready (commit_ready),
      .rf_we        (rf_we),
      .rf_waddr     (rf_waddr),
      .rf_wdata     (rf_wdata),
      .commit_valid (commit_valid),
      .commit_pc    (commit_pc),
      .fwd_valid    (fwd_valid),
      .fwd_addr     (fwd_addr),
      .fwd_data     (fwd_data),
      .instret      (instret)
   );

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] ref_load(input logic [63:0] rdata,
                                            input int off, input int fmt);
      int          size;
      int          start;
      logic [63:0] mask;
      logic [63:0] v;
      case (fmt)
         0, 4:    size = 1;
         1, 5:    size = 2;
         2, 6:    size = 4;
         default: size = 8;
      endcase
      start = (off / size) * size;
      v     = rdata >> (start * 8);
      mask  = (size == 8) ? {64{1'b1}} : ((64'd1 << (size * 8)) - 64'd1);
      v     = v & mask;
      if (fmt < 3 && v[size*8-1])
         v = v | ~mask;
      return v;
   endfunction

   function automatic logic [63:0] ref_result();
      case (in_sel)
         2'd0:    return in_alu;
         2'd1:    return ref_load(in_mem_rdata, int'(in_mem_off),
                                  int'(in_mem_fmt));
         2'd2:    return in_pc + 64'd4;
         default: return in_csr;
      endcase
   endfunction

   task automatic model_reset();
      m_valid   = 0;
      m_pc      = '0;
      m_rd      = '0;
      m_we      = 0;
      m_res     = '0;
      m_instret = '0;
   endtask

   // Compare at the falling edge, then advance the model with the rising edge.
   task automatic cycle();
      bit          ret;
      bit          acc;
      logic [63:0] nres;
      @(negedge clk);
      chk("in_ready", in_ready, !m_valid || commit_ready);
      chk("commit_valid", commit_valid, m_valid && commit_ready);
      chk("rf_we", rf_we, m_valid && commit_ready && m_we && m_rd != 0);
      chk("fwd_valid", fwd_valid, m_valid && m_we && m_rd != 0);
      chk("instret", instret, m_instret);
      if (m_valid) begin
         chk("commit_pc", commit_pc, m_pc);
         chk("rf_waddr", rf_waddr, m_rd);
         chk("rf_wdata", rf_wdata, m_res);
         chk("fwd_addr", fwd_addr, m_rd);
         chk("fwd_data", fwd_data, m_res);
      end
      ret  = m_valid && commit_ready;
      acc  = in_valid && (!m_valid || commit_ready);
      nres = ref_result();
      @(posedge clk);
      if (ret) m_instret = m_instret + 64'd1;
      if (acc) begin
         m_valid = 1;
         m_pc    = in_pc;
         m_rd    = in_rd;
         m_we    = in_rd_we;
         m_res   = nres;
      end else if (ret) begin
         m_valid = 0;
      end
      #1;
   endtask

   task automatic drive(input bit v, input logic [63:0] pc,
                        input logic [4:0] rd, input bit we,
                        input logic [1:0] sel, input logic [63:0] alu);
      in_valid = v;
      in_pc    = pc;
      in_rd    = rd;
      in_rd_we = we;
      in_sel   = sel;
      in_alu   = alu;
   endtask

   // Assert reset partway through a cycle; outputs must clear at once.
   task automatic reset_mid();
      #2;
      rst_n = 1'b0;
      commit_ready = 1'b0;
      #1;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_rf_we", rf_we, 0);
      chk("rst_commit_valid", commit_valid, 0);
      chk("rst_fwd_valid", fwd_valid, 0);
      chk("rst_commit_pc", commit_pc, 0);
      chk("rst_rf_waddr", rf_waddr, 0);
      chk("rst_rf_wdata", rf_wdata, 0);
      chk("rst_fwd_addr", fwd_addr, 0);
      chk("rst_fwd_data", fwd_data, 0);
      chk("rst_instret", instret, 0);
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic [1:0]  sel;
      logic [2:0]  fmt;
      logic [2:0]  off;
      logic [63:0] rdata;
      logic [63:0] pc;
      logic [63:0] csr;
      logic [63:0] exp;
   } vec_t;

   localparam logic [63:0] RD = 64'h8877_6655_4433_22F0;

   vec_t tbl[11];

   initial begin
      logic [63:0] held;
      logic [63:0] i0;

      tbl[0]  = '{2'd1, 3'd0, 3'd0, RD, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFF0};
      tbl[1]  = '{2'd1, 3'd4, 3'd0, RD, 64'h0, 64'h0, 64'h0000_0000_0000_00F0};
      tbl[2]  = '{2'd1, 3'd1, 3'd6, RD, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_8877};
      tbl[3]  = '{2'd1, 3'd6, 3'd4, RD, 64'h0, 64'h0, 64'h0000_0000_8877_6655};
      tbl[4]  = '{2'd1, 3'd1, 3'd7, RD, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_8877};
      tbl[5]  = '{2'd1, 3'd2, 3'd5, RD, 64'h0, 64'h0, 64'hFFFF_FFFF_8877_6655};
      tbl[6]  = '{2'd1, 3'd5, 3'd2, RD, 64'h0, 64'h0, 64'h0000_0000_0000_4433};
      tbl[7]  = '{2'd1, 3'd7, 3'd3, RD, 64'h0, 64'h0, RD};
      tbl[8]  = '{2'd1, 3'd0, 3'd5, RD, 64'h0, 64'h0, 64'h0000_0000_0000_0066};
      tbl[9]  = '{2'd2, 3'd0, 3'd0, RD, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 64'h0};
      tbl[10] = '{2'd3, 3'd0, 3'd0, RD, 64'h1000, 64'hC5C5_0000_1234_5678,
                  64'hC5C5_0000_1234_5678};

      rst_n        = 1'b0;
      commit_ready = 1'b0;
      drive(0, 64'h0, 5'd0, 0, 2'd0, 64'h0);
      in_csr       = '0;
      in_mem_rdata = '0;
      in_mem_off   = '0;
      in_mem_fmt   = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Idle entry, then a mid-cycle reset on top of a held entry.
      drive(1, 64'h8000_0000, 5'd3, 1, 2'd0, 64'hABCD);
      cycle();
      reset_mid();

      // ALU back-to-back.
      commit_ready = 1'b1;
      drive(1, 64'h100, 5'd5, 1, 2'd0, 64'h11);
      cycle();
      drive(1, 64'h104, 5'd6, 1, 2'd0, 64'h22);
      cycle();
      drive(1, 64'h108, 5'd7, 1, 2'd0, 64'h33);
      cycle();
      in_valid = 1'b0;
      cycle();
      chk("alu_instret", instret, 64'd3);

      // Vector table: loads, PC+4 wrap, CSR.
      foreach (tbl[i]) begin
         drive(1, tbl[i].pc, 5'd10, 1, tbl[i].sel, 64'h0);
         in_csr       = tbl[i].csr;
         in_mem_rdata = tbl[i].rdata;
         in_mem_off   = tbl[i].off;
         in_mem_fmt   = tbl[i].fmt;
         cycle();
         in_valid = 1'b0;
         chk($sformatf("tbl%0d_wdata", i), rf_wdata, tbl[i].exp);
         cycle();
      end

      // Backpressure with a pending next entry.
      drive(1, 64'h200, 5'd9, 1, 2'd0, 64'hAA);
      cycle();
      held = fwd_data;
      commit_ready = 1'b0;
      drive(1, 64'h204, 5'd12, 1, 2'd0, 64'hBB);
      repeat (4) begin
         cycle();
         chk("bp_in_ready", in_ready, 0);
         chk("bp_rf_we", rf_we, 0);
         chk("bp_fwd_valid", fwd_valid, 1);
         chk("bp_fwd_data", fwd_data, 64'hAA);
         chk("bp_stable", fwd_data, held);
      end
      i0 = instret;
      commit_ready = 1'b1;
      #1;
      chk("bp_rel_commit", commit_valid, 1);
      chk("bp_rel_ready", in_ready, 1);
      cycle();
      in_valid = 1'b0;
      chk("bp_rel_instret", instret, i0 + 64'd1);
      chk("bp_next_addr", fwd_addr, 5'd12);
      chk("bp_next_data", fwd_data, 64'hBB);
      cycle();

      // Write to x0 still retires and counts.
      drive(1, 64'h300, 5'd0, 1, 2'd0, 64'h55);
      cycle();
      in_valid = 1'b0;
      chk("x0_rf_we", rf_we, 0);
      chk("x0_commit", commit_valid, 1);
      chk("x0_fwd_valid", fwd_valid, 0);
      i0 = instret;
      cycle();
      chk("x0_instret", instret, i0 + 64'd1);

      // Reset while an entry is held under backpressure.
      reset_mid();
      commit_ready = 1'b1;
      drive(1, 64'h400, 5'd8, 1, 2'd0, 64'h77);
      cycle();
      in_valid = 1'b0;
      commit_ready = 1'b0;
      cycle();
      #2;
      rst_n = 1'b0;
      #1;
      chk("rh_commit", commit_valid, 0);
      chk("rh_rf_we", rf_we, 0);
      chk("rh_instret", instret, 0);
      model_reset();
      commit_ready = 1'b1;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cycle();
      chk("rh_instret_after", instret, 0);

      // Random traffic against the model.
      for (int n = 0; n < 600; n++) begin
         in_valid     = ($urandom_range(0, 3) != 0);
         commit_ready = ($urandom_range(0, 3) != 0);
         in_pc        = {$urandom, $urandom};
         in_rd        = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
         in_rd_we     = ($urandom_range(0, 4) != 0);
         in_sel       = 2'($urandom);
         in_alu       = {$urandom, $urandom};
         in_csr       = {$urandom, $urandom};
         in_mem_rdata = {$urandom, $urandom};
         in_mem_off   = 3'($urandom);
         in_mem_fmt   = 3'($urandom);
         cycle();
      end
      in_valid     = 1'b0;
      commit_ready = 1'b1;
      cycle();
      cycle();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
